clock_display_mux: RTL

//   Downstream consumer of the 12-hour clock core. Takes packed-BCD hours/minutes plus PM flag,

---
 rtl/clock_display_pkg.sv | 27 ++
 rtl/bcd_to_seg7.sv | 24 ++
 rtl/clock_display_mux.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/clock_display_pkg.sv
// +----------------------------------------------------------------------------+
// | clock_display_pkg                                                          |
// | Glyph constants and digit-index types for the 4-digit clock display.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package clock_display_pkg;

  typedef logic [1:0] dig_idx_t;

  localparam dig_idx_t DIG_HT = 2'd0;  // hours tens (leftmost)
  localparam dig_idx_t DIG_HO = 2'd1;  // hours ones, carries the colon
  localparam dig_idx_t DIG_MT = 2'd2;  // minutes tens
  localparam dig_idx_t DIG_MO = 2'd3;  // minutes ones

  // Segment order is {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// +----------------------------------------------------------------------------+
// | bcd_to_seg7                                                                |
// | Combinational BCD nibble to 7-segment glyph; non-decimal codes give a dash.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_to_seg7
  import clock_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_DASH;
    if (nibble <= 4'd9) begin
      glyph = SEG_DIGIT[nibble];
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_display_mux.sv
// +----------------------------------------------------------------------------+
// | clock_display_mux                                                          |
// | Scans hh:mm onto a 4-digit common-cathode display with a blinking colon.   |
// | Optional macro PM_DOT_EN: digit 3 decimal point shows the PM flag.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module clock_display_mux
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       disp_en,
  input  logic [7:0] hh_bcd,
  input  logic [7:0] mm_bcd,
  input  logic       pm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig_en
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] c_frm_last = FRM_W'(BLINK_FRAMES - 1);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("clock_display_mux: SCAN_DIV must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("clock_display_mux: BLINK_FRAMES must be >= 1");
  end

  logic [DIV_W-1:0] r_div,       w_div_nxt;
  dig_idx_t         r_dig_idx,   w_dig_idx_nxt;
  logic [FRM_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic             r_colon_on,  w_colon_on_nxt;
  logic [7:0]       r_hh_snap;
  logic [7:0]       r_mm_snap;
  logic [6:0]       r_seg,       w_seg_nxt;
  logic             r_dp,        w_dp_nxt;
  logic [3:0]       r_dig_en,    w_dig_en_nxt;
  logic             w_snap_en;
  logic [3:0]       w_nibble;
  logic [6:0]       w_glyph;
  logic             w_lead_blank;

`ifdef PM_DOT_EN
  logic r_pm_snap;
`else
  logic w_pm_unused;
  assign w_pm_unused = pm;
`endif

  // Snapshot at the blank cycle opening each frame so all four digits agree
  assign w_snap_en = disp_en && (r_div == '0) && (r_dig_idx == DIG_HT);

  always_comb begin
    w_nibble = r_mm_snap[3:0];
    case (r_dig_idx)
      DIG_HT:  w_nibble = r_hh_snap[7:4];
      DIG_HO:  w_nibble = r_hh_snap[3:0];
      DIG_MT:  w_nibble = r_mm_snap[7:4];
      default: w_nibble = r_mm_snap[3:0];
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .nibble (w_nibble),
    .glyph  (w_glyph)
  );

  assign w_lead_blank = (r_dig_idx == DIG_HT) && (r_hh_snap[7:4] == 4'd0);

  always_comb begin
    w_div_nxt       = r_div;
    w_dig_idx_nxt   = r_dig_idx;
    w_frame_cnt_nxt = r_frame_cnt;
    w_colon_on_nxt  = r_colon_on;
    w_seg_nxt       = SEG_BLANK;
    w_dp_nxt        = 1'b0;
    w_dig_en_nxt    = 4'b0000;

    if (disp_en) begin
      if (r_div == c_div_last) begin
        w_div_nxt     = '0;
        w_dig_idx_nxt = r_dig_idx + 2'd1;
        if (r_dig_idx == DIG_MO) begin
          if (r_frame_cnt == c_frm_last) begin
            w_frame_cnt_nxt = '0;
            w_colon_on_nxt  = ~r_colon_on;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 1'b1;
          end
        end
      end else begin
        w_div_nxt = r_div + 1'b1;
      end

      // div==0 stays dark so the previous digit's segments cannot ghost
      if (r_div != '0) begin
        w_dig_en_nxt = 4'b0001 << r_dig_idx;
        w_seg_nxt    = w_lead_blank ? SEG_BLANK : w_glyph;
        case (r_dig_idx)
          DIG_HO:  w_dp_nxt = r_colon_on;
`ifdef PM_DOT_EN
          DIG_MO:  w_dp_nxt = r_pm_snap;
`endif
          default: w_dp_nxt = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_dig_idx   <= DIG_HT;
      r_frame_cnt <= '0;
      r_colon_on  <= 1'b1;
      r_hh_snap   <= 8'h00;
      r_mm_snap   <= 8'h00;
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b0;
      r_dig_en    <= 4'b0000;
    end else begin
      r_div       <= w_div_nxt;
      r_dig_idx   <= w_dig_idx_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_colon_on  <= w_colon_on_nxt;
      r_seg       <= w_seg_nxt;
      r_dp        <= w_dp_nxt;
      r_dig_en    <= w_dig_en_nxt;
      if (w_snap_en) begin
        r_hh_snap <= hh_bcd;
        r_mm_snap <= mm_bcd;
      end
    end
  end

`ifdef PM_DOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm_snap <= 1'b0;
    end else if (w_snap_en) begin
      r_pm_snap <= pm;
    end
  end
`endif

  assign seg    = r_seg;
  assign dp     = r_dp;
  assign dig_en = r_dig_en;

endmodule

`default_nettype wire
